// File: rtl/add_4bit.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and
// signed-overflow / zero status flags, qualified by a one-cycle valid strobe.
// The adder itself is combinational; only the results are flopped, so a
// result sampled at one edge is visible right after that edge.
module add_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Cin,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  // The overflow flag compares the carries into and out of the MSB, so
  // a single-bit adder has no meaningful signed overflow.
  if (WIDTH < 2) begin : g_width_check
    $error("add_4bit: WIDTH must be >= 2");
  end

  // Carry chain: c[0] is the carry-in, c[WIDTH] the carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ovf_d;
  logic             zero_d;

  assign carry[0] = Cin;

  // One full-adder cell per bit; the carry ripples from LSB to MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic half;
    assign half         = x[i] ^ y[i];
    assign sum[i]       = half ^ carry[i];
    assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & half);
  end

  // Signed overflow: the carry into the sign bit disagrees with the carry
  // out of it. Zero looks only at the WIDTH-bit sum, never at Cout.
  assign ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
  assign zero_d = (sum == '0);

  // Output registers: load a new result on a valid beat, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    // The reset value of zero is 1 so the flags agree with out == 0.
    if (!rst_n) begin
      out  <= '0;
      Cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b1;
    end else if (in_valid) begin
      out  <= sum;
      Cout <= carry[WIDTH];
      ovf  <= ovf_d;
      zero <= zero_d;
    end
  end

  // Valid strobe: high for exactly the cycle following an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_add_4bit.sv
// Self-checking bench for add_4bit: a driver issues directed, exhaustive and
// random beats; an expected result is queued for every beat the adder
// accepts, and an independent monitor compares what the adder presents.
module tb_add_4bit;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic         zero;
  } result_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         Cin;
  logic [W-1:0] out;
  logic         Cout;
  logic         ovf;
  logic         zero;
  logic         out_valid;

  int tests = 0;
  int fails = 0;

  result_t exp_q[$];
  result_t held;
  logic    exp_valid;

  add_4bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .Cin       (Cin),
    .out       (out),
    .Cout      (Cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, unsigned and signed views.
  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c);
    result_t     r;
    int unsigned total;
    int          stotal;
    total  = int'(a) + int'(b) + int'(c);
    stotal = int'($signed(a)) + int'($signed(b)) + int'(c);
    r.out  = W'(total % (2 ** W));
    r.cout = (total >= (2 ** W));
    r.ovf  = (stotal > (2 ** (W - 1)) - 1) || (stotal < -(2 ** (W - 1)));
    r.zero = ((total % (2 ** W)) == 0);
    return r;
  endfunction

  function automatic result_t reset_result();
    result_t r;
    r.out  = '0;
    r.cout = 1'b0;
    r.ovf  = 1'b0;
    r.zero = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_result(input string name, input result_t exp);
    check({name, ".out"},  32'(out),  32'(exp.out));
    check({name, ".cout"}, 32'(Cout), 32'(exp.cout));
    check({name, ".ovf"},  32'(ovf),  32'(exp.ovf));
    check({name, ".zero"}, 32'(zero), 32'(exp.zero));
  endtask

  // Scoreboard producer: every beat the adder should accept queues its answer;
  // reset throws away anything not yet presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      held      = reset_result();
      exp_valid = 1'b0;
    end else begin
      exp_valid = in_valid;
      if (in_valid) exp_q.push_back(model(x, y, Cin));
    end
  end

  // Monitor: away from the active edge, compare the presented result with the
  // queue head, or with the last result while no new one is presented.
  always @(negedge clk) begin
    result_t e;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check_result("result", e);
        held = e;
      end
    end else begin
      check_result("hold", held);
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    @(negedge clk);
    in_valid = v;
    x        = a;
    y        = b;
    Cin      = c;
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    Cin      = 1'b0;

    // Asynchronous reset, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_result("async_reset", reset_result());
    check("async_reset.out_valid", 32'(out_valid), 32'(0));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed sums.
    drive(1'b1, 4'b1000, 4'b1001, 1'b0);
    drive(1'b1, 4'b1000, 4'b1001, 1'b1);
    drive(1'b1, 4'b1101, 4'b1001, 1'b1);
    drive(1'b1, 4'b1101, 4'b0110, 1'b1);
    drive(1'b1, 4'b1101, 4'b0110, 1'b0);
    drive(1'b1, 4'b1000, 4'b0110, 1'b0);
    drive(1'b1, 4'b1000, 4'b1001, 1'b0);

    // Boundaries: wrap to zero, signed overflow into the sign bit, all zeros.
    drive(1'b1, 4'b1111, 4'b0000, 1'b1);
    drive(1'b1, 4'b0111, 4'b0001, 1'b0);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0);

    // Hold: capture 0111, then three idle cycles with changing operands.
    drive(1'b1, 4'b1101, 4'b1001, 1'b1);
    drive(1'b0, 4'b0011, 4'b0101, 1'b1);
    drive(1'b0, 4'b1111, 4'b1111, 1'b0);
    drive(1'b0, 4'b0001, 4'b1010, 1'b1);

    // Exhaustive sweep of (x, y, Cin), one beat per cycle.
    for (int i = 0; i < 2 ** (2 * W + 1); i++) begin
      logic [2*W:0] v;
      v = (2 * W + 1)'(i);
      drive(1'b1, v[W-1:0], v[2*W-1:W], v[2*W]);
    end

    // Random beats with random idle gaps.
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(3, 0) != 0), W'($urandom), W'($urandom), 1'($urandom));
    end

    // Reset mid-stream: a freshly captured result is discarded, edges during
    // reset are ignored, and the next result follows a post-release beat.
    drive(1'b1, 4'b0101, 4'b0100, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_result("midstream_reset", reset_result());
    check("midstream_reset.out_valid", 32'(out_valid), 32'(0));
    drive(1'b1, 4'b0011, 4'b0011, 1'b1);
    @(posedge clk);
    #1;
    check_result("reset_ignores_edge", reset_result());
    @(negedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    x        = 4'b0110;
    y        = 4'b0011;
    Cin      = 1'b0;
    drive(1'b1, 4'b1111, 4'b1111, 1'b1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);

    #1;
    check("drain", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
